fp_adder_top: RTL and testbench
===============================

FP_ADDER_TOP -- requirements
Module: fp_adder

Interface
REQ-001 Parameter EXP_W, default 9: exponent field width.
REQ-002 Parameter MAN_W, default 30: mantissa field width; word width W = EXP_W+MAN_W = 39.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands valid this cycle.
REQ-006 a_original  input  W  operand A: [W-1:MAN_W] unsigned exponent, [MAN_W-1:0] mantissa.
REQ-007 b_original  input  W  operand B, same format.
REQ-008 sum  output  W  registered result, same format.
REQ-009 kh  output  1  registered overflow flag for the result in sum.
REQ-010 out_valid  output  1  sum/kh valid.

Function
REQ-011 Unsigned format: value = 0.mantissa x 2^exponent; mantissa bit MAN_W-1 is an explicit leading one; no sign, no bias, no NaN/Inf.
REQ-012 Inputs SHALL be normalized (MSB=1) or zero (mantissa=0); an unnormalized input SHALL be processed as-is, with no left normalization of the result.
REQ-013 A zero operand SHALL yield the other operand unchanged; both zero yields all-zero sum.
REQ-014 Alignment: the operand with the smaller exponent is shifted right by the exponent difference; a difference >= MAN_W contributes zero; equal exponents need no shift.
REQ-015 Mantissas are added at MAN_W+1 bits; on carry-out the result shifts right one and the exponent increments; otherwise the larger exponent is kept.
REQ-016 Bits shifted out are truncated (unless REQ-025 applies).
REQ-017 Overflow: exponent increment beyond 2^EXP_W-1 SHALL saturate sum to exponent all-ones, mantissa all-ones, with kh=1; otherwise kh=0.
REQ-018 Latency exactly 1 cycle: operands sampled on the edge where in_valid=1 appear on sum/kh with out_valid=1 after that edge.
REQ-019 out_valid follows in_valid delayed by one cycle; back-to-back inputs give one result per cycle; no backpressure.
REQ-020 When in_valid=0, sum and kh SHALL hold their previous values.
REQ-021 Operation is commutative: swapping a_original/b_original gives a bit-identical result.

Reset
REQ-022 rst_n low SHALL immediately clear sum, kh and out_valid to 0, independent of clk.
REQ-023 A result in flight when reset asserts SHALL be discarded; the first valid output after deassertion comes from the first in_valid sampled after it.

Configuration
REQ-024 Macro FP_ADDER_ROUND_EN selects the rounding mode.
REQ-025 With FP_ADDER_ROUND_EN defined: round-to-nearest-even using guard, round and sticky bits collected during alignment and the carry shift; a rounding carry SHALL renormalize and may trigger REQ-017.
REQ-026 Without FP_ADDER_ROUND_EN: truncation as in REQ-016; latency is 1 cycle in both modes.

Structure
REQ-027 Shared package fp_pkg SHALL hold EXP_W, MAN_W, the fp word typedef (exponent/mantissa struct) and the saturation constant.
REQ-028 Combinational sub-module fp_align_shift SHALL perform the right shift by exponent difference and produce the sticky bit; compare/add/normalize/register logic stays in fp_adder.

Verification
REQ-029 A=exp 0, man 1101 followed by 26 zeros; B=exp 0, man 111 followed by 27 zeros -> sum exp 1, man 11011 followed by 25 zeros, kh=0.
REQ-030 A=exp 5, man 1101 followed by 26 zeros; B=exp 15, man 111 followed by 27 zeros -> sum exp 15, man 11100000001101 followed by 16 zeros, kh=0.
REQ-031 A=exp 511, man all-ones; B=exp 511, man all-ones -> sum exp 511, man all-ones, kh=1.
REQ-032 A=exp 40, man 1 followed by 29 zeros; B=exp 2, any mantissa -> sum equals A (difference >= 30), kh=0.
REQ-033 A=exp 7, man 1 followed by 29 zeros; B=zero -> sum equals A; swapping operands gives the same result.
REQ-034 Assert rst_n low mid-stream with in_valid=1 -> sum, kh and out_valid are 0 immediately; after release, out_valid rises exactly 1 cycle after the next in_valid.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the unsigned floating-point adder.
// Word format: [W-1:MAN_W] unsigned exponent, [MAN_W-1:0] mantissa,
// value = 0.mantissa x 2^exponent, mantissa MSB is an explicit leading one.
package fp_pkg;

    localparam int EXP_W = 9;
    localparam int MAN_W = 30;
    localparam int W     = EXP_W + MAN_W;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_word_t;

    // Result forced on exponent overflow.
    localparam fp_word_t FP_SAT = '{exp: {EXP_W{1'b1}}, man: {MAN_W{1'b1}}};

    // Builds a word from separate fields.
    function automatic fp_word_t fp_pack(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        fp_word_t w;
        w.exp = e;
        w.man = m;
        return w;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Right-shift of the smaller operand's mantissa by the exponent difference.
// Macro FP_ADDER_ROUND_EN: when defined, also produces the guard, round and
// sticky bits of everything shifted out; otherwise shifted-out bits are dropped.
module fp_align_shift #(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int MAN_W = fp_pkg::MAN_W
) (
    input  logic [MAN_W-1:0] i_man,
    input  logic [EXP_W-1:0] i_shift,
`ifdef FP_ADDER_ROUND_EN
    output logic             o_guard,
    output logic             o_round,
    output logic             o_sticky,
`endif
    output logic [MAN_W-1:0] o_man
);

`ifdef FP_ADDER_ROUND_EN
    // Mantissa sits on top of MAN_W+2 extra bits: guard, round, then a field
    // that collects sticky bits. Clamping the shift at MAN_W+2 drops the whole
    // mantissa into the sticky field, which is exactly the far-shift answer.
    localparam int               WIDE     = 2 * MAN_W + 2;
    localparam logic [EXP_W-1:0] SH_CLAMP = EXP_W'(MAN_W + 2);

    logic [EXP_W-1:0] w_sh;
    logic [WIDE-1:0]  w_wide;

    // Clamped wide shift
    always_comb begin
        w_sh   = (i_shift > SH_CLAMP) ? SH_CLAMP : i_shift;
        w_wide = {i_man, {(MAN_W + 2){1'b0}}} >> w_sh;
    end

    assign o_man    = w_wide[WIDE-1:MAN_W+2];
    assign o_guard  = w_wide[MAN_W+1];
    assign o_round  = w_wide[MAN_W];
    assign o_sticky = |w_wide[MAN_W-1:0];
`else
    localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MAN_W);

    // Truncating shift; a difference of MAN_W or more leaves nothing
    always_comb begin
        if (i_shift >= SH_MAX) o_man = '0;
        else                   o_man = i_man >> i_shift;
    end
`endif

endmodule

// File: rtl/fp_adder_top.sv
// Unsigned floating-point adder, one-cycle latency, registered outputs.
// Compare/select, mantissa add, carry renormalization, overflow saturation
// and output register live here; alignment shifting is in fp_align_shift.
// Macro FP_ADDER_ROUND_EN: round-to-nearest-even instead of truncation.
module fp_adder_top #(
    parameter  int EXP_W = fp_pkg::EXP_W,
    parameter  int MAN_W = fp_pkg::MAN_W,
    localparam int W     = EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] a_original,
    input  logic [W-1:0] b_original,
    output logic [W-1:0] sum,
    output logic         kh,
    output logic         out_valid
);

    localparam logic [EXP_W+1:0] EXP_ONE = {{(EXP_W + 1){1'b0}}, 1'b1};

    logic [EXP_W-1:0] w_exp_a;
    logic [EXP_W-1:0] w_exp_b;
    logic [MAN_W-1:0] w_man_a;
    logic [MAN_W-1:0] w_man_b;
    logic             w_zero_a;
    logic             w_zero_b;
    logic             w_a_big;
    logic [EXP_W-1:0] w_exp_big;
    logic [EXP_W-1:0] w_exp_small;
    logic [MAN_W-1:0] w_man_big;
    logic [MAN_W-1:0] w_man_small;
    logic [EXP_W-1:0] w_diff;
    logic [MAN_W-1:0] w_man_aligned;
    logic [MAN_W:0]   w_add;
    logic [EXP_W+1:0] w_exp_res;
    logic [MAN_W-1:0] w_man_res;
    logic             w_ovf;
    logic [W-1:0]     w_sum_next;
    logic             w_kh_next;

    logic [W-1:0]     r_sum;
    logic             r_kh;
    logic             r_out_valid;

`ifdef FP_ADDER_ROUND_EN
    logic             w_guard;
    logic             w_round;
    logic             w_sticky;
    logic             w_g;
    logic             w_s;
    logic             w_round_up;
    logic [MAN_W:0]   w_man_rnd;
`endif

    assign w_exp_a  = a_original[W-1:MAN_W];
    assign w_exp_b  = b_original[W-1:MAN_W];
    assign w_man_a  = a_original[MAN_W-1:0];
    assign w_man_b  = b_original[MAN_W-1:0];
    assign w_zero_a = (w_man_a == '0);
    assign w_zero_b = (w_man_b == '0);

    // On equal exponents neither side shifts, so the tie choice cannot break
    // commutativity.
    assign w_a_big     = (w_exp_a >= w_exp_b);
    assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
    assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;
    assign w_man_big   = w_a_big ? w_man_a : w_man_b;
    assign w_man_small = w_a_big ? w_man_b : w_man_a;
    assign w_diff      = w_exp_big - w_exp_small;

    fp_align_shift #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_align (
        .i_man    (w_man_small),
        .i_shift  (w_diff),
`ifdef FP_ADDER_ROUND_EN
        .o_guard  (w_guard),
        .o_round  (w_round),
        .o_sticky (w_sticky),
`endif
        .o_man    (w_man_aligned)
    );

    assign w_add = {1'b0, w_man_big} + {1'b0, w_man_aligned};

    // Carry renormalization (and rounding when enabled); exponent kept two
    // bits wider so an overflow is visible before saturation.
    always_comb begin
        w_exp_res = {2'b00, w_exp_big};
        w_man_res = w_add[MAN_W-1:0];
        if (w_add[MAN_W]) begin
            w_exp_res = w_exp_res + EXP_ONE;
            w_man_res = w_add[MAN_W:1];
        end
`ifdef FP_ADDER_ROUND_EN
        // The carry shift pushes the sum LSB into the guard position and the
        // alignment bits all collapse into sticky.
        if (w_add[MAN_W]) begin
            w_g = w_add[0];
            w_s = w_guard | w_round | w_sticky;
        end else begin
            w_g = w_guard;
            w_s = w_round | w_sticky;
        end
        w_round_up = w_g & (w_s | w_man_res[0]);
        w_man_rnd  = {1'b0, w_man_res} + {{MAN_W{1'b0}}, w_round_up};
        if (w_man_rnd[MAN_W]) begin
            w_exp_res = w_exp_res + EXP_ONE;
            w_man_res = {1'b1, {(MAN_W - 1){1'b0}}};
        end else begin
            w_man_res = w_man_rnd[MAN_W-1:0];
        end
`endif
    end

    assign w_ovf = |w_exp_res[EXP_W+1:EXP_W];

    // Result select: zero bypass, saturation, or normal sum
    always_comb begin
        w_sum_next = {w_exp_res[EXP_W-1:0], w_man_res};
        w_kh_next  = 1'b0;
        if (w_zero_a && w_zero_b) begin
            w_sum_next = '0;
        end else if (w_zero_a) begin
            w_sum_next = b_original;
        end else if (w_zero_b) begin
            w_sum_next = a_original;
        end else if (w_ovf) begin
            w_sum_next = fp_pkg::FP_SAT;
            w_kh_next  = 1'b1;
        end
    end

    // Output register: capture on valid, hold otherwise, flush on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_kh        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum <= w_sum_next;
                r_kh  <= w_kh_next;
            end
        end
    end

    assign sum       = r_sum;
    assign kh        = r_kh;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fp_adder_top.sv
// Self-checking bench for fp_adder_top: directed cases, randomized
// back-to-back traffic against an exact-arithmetic model, hold and reset.
module tb_fp_adder_top;
    import fp_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a_original;
    logic [W-1:0] b_original;
    logic [W-1:0] sum;
    logic         kh;
    logic         out_valid;

    int n_checks = 0;
    int n_errors = 0;

    fp_adder_top dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a_original (a_original),
        .b_original (b_original),
        .sum        (sum),
        .kh         (kh),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact sum held with 32 fraction bits below the larger operand's LSB
    // plus a sticky flag for anything finer; then truncate or round-to-even.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned ma, mb, mx, mn, acc, man, rem;
        int ea, eb, ex, d;
        bit sticky;
        ma = 64'(a[MAN_W-1:0]);
        mb = 64'(b[MAN_W-1:0]);
        ea = int'(a[W-1:MAN_W]);
        eb = int'(b[W-1:MAN_W]);
        if (ma == 0 && mb == 0) return '0;
        if (ma == 0) return {1'b0, b};
        if (mb == 0) return {1'b0, a};
        if (ea >= eb) begin mx = ma; mn = mb; ex = ea; d = ea - eb; end
        else          begin mx = mb; mn = ma; ex = eb; d = eb - ea; end
        sticky = 1'b0;
        acc = mx << 32;
        if (d <= 32) acc += mn << (32 - d);
        else if (d < 64) begin
            acc += mn >> (d - 32);
            sticky = (mn & ((64'd1 << (d - 32)) - 1)) != 0;
        end else sticky = (mn != 0);
        if (acc >= (64'd1 << (MAN_W + 32))) begin
            sticky = sticky | acc[0];
            acc = acc >> 1;
            ex++;
        end
        man = acc >> 32;
        rem = acc & 64'hFFFF_FFFF;
`ifdef FP_ADDER_ROUND_EN
        if (rem > 64'h8000_0000 || (rem == 64'h8000_0000 && (sticky || man[0])))
            man++;
        if (man == (64'd1 << MAN_W)) begin
            man = man >> 1;
            ex++;
        end
`endif
        if (ex > (1 << EXP_W) - 1) return {1'b1, FP_SAT};
        return {1'b0, ex[EXP_W-1:0], man[MAN_W-1:0]};
    endfunction

    function automatic logic [W-1:0] mk(input int e, input logic [MAN_W-1:0] m);
        return fp_pack(e[EXP_W-1:0], m);
    endfunction

    function automatic logic [MAN_W-1:0] rand_man();
        int sel;
        sel = $urandom_range(0, 19);
        if (sel < 2) return '0;
        if (sel < 3) return MAN_W'($urandom);
        return {1'b1, 29'($urandom)};
    endfunction

    function automatic int clamp_exp(input int e);
        if (e < 0) return 0;
        if (e > 511) return 511;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a_original = '0; b_original = '0;
        #3;
        n_checks++;
        if (sum !== '0 || kh !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got sum=%h kh=%b ov=%b, want 0 0 0", sum, kh, out_valid);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[6], tb[6], te[6];
        logic         tk[6];
        ta[0] = mk(0, {4'b1101, 26'd0});   tb[0] = mk(0, {3'b111, 27'd0});
        te[0] = mk(1, {5'b11011, 25'd0});  tk[0] = 1'b0;
        ta[1] = mk(5, {4'b1101, 26'd0});   tb[1] = mk(15, {3'b111, 27'd0});
        te[1] = mk(15, {14'b11100000001101, 16'd0}); tk[1] = 1'b0;
        ta[2] = mk(511, '1);               tb[2] = mk(511, '1);
        te[2] = mk(511, '1);               tk[2] = 1'b1;
        ta[3] = mk(40, {1'b1, 29'd0});     tb[3] = mk(2, 30'h2ABCDEF1);
        te[3] = ta[3];                     tk[3] = 1'b0;
        ta[4] = mk(7, {1'b1, 29'd0});      tb[4] = '0;
        te[4] = ta[4];                     tk[4] = 1'b0;
        ta[5] = '0;                        tb[5] = mk(7, {1'b1, 29'd0});
        te[5] = tb[5];                     tk[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_original = ta[i]; b_original = tb[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (sum !== te[i] || kh !== tk[i] || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL directed[%0d]: got sum=%h kh=%b ov=%b, want sum=%h kh=%b ov=1",
                         i, sum, kh, out_valid, te[i], tk[i]);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL directed_ov_drop[%0d]: got ov=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [W:0]   exp_prev;
        logic [W-1:0] a, b;
        int ea, eb, mode;
        bit have;
        have = 1'b0;
        exp_prev = '0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (have) begin
                n_checks++;
                if ({kh, sum} !== exp_prev || out_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b[%0d]: got kh=%b sum=%h ov=%b, want kh=%b sum=%h ov=1",
                             i - 1, kh, sum, out_valid, exp_prev[W], exp_prev[W-1:0]);
                end
            end
            if (i == n) begin
                in_valid = 1'b0;
            end else begin
                mode = $urandom_range(0, 4);
                ea = (mode == 4) ? $urandom_range(505, 511) : $urandom_range(0, 511);
                case (mode)
                    0:       eb = clamp_exp(ea + $urandom_range(0, 6) - 3);
                    1:       eb = clamp_exp(ea - $urandom_range(28, 34));
                    2:       eb = $urandom_range(0, 511);
                    default: eb = clamp_exp(ea - $urandom_range(0, 1));
                endcase
                a = mk(ea, rand_man());
                b = mk(eb, rand_man());
                if ($urandom_range(0, 1) == 1) begin
                    a_original = b; b_original = a;
                end else begin
                    a_original = a; b_original = b;
                end
                in_valid = 1'b1;
                exp_prev = ref_add(a, b);
                have = 1'b1;
            end
        end
    endtask

    task automatic test_commutative(input int n);
        logic [W-1:0] a, b;
        logic [W:0]   e;
        for (int i = 0; i < n; i++) begin
            a = mk($urandom_range(100, 110), {1'b1, 29'($urandom)});
            b = mk($urandom_range(100, 110), {1'b1, 29'($urandom)});
            e = ref_add(a, b);
            @(negedge clk);
            a_original = a; b_original = b; in_valid = 1'b1;
            @(negedge clk);
            a_original = b; b_original = a;
            n_checks++;
            if ({kh, sum} !== e) begin
                n_errors++;
                $display("FAIL comm_ab[%0d]: got kh=%b sum=%h, want kh=%b sum=%h", i, kh, sum, e[W], e[W-1:0]);
            end
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if ({kh, sum} !== e) begin
                n_errors++;
                $display("FAIL comm_ba[%0d]: got kh=%b sum=%h, want kh=%b sum=%h", i, kh, sum, e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] a, b;
        logic [W:0]   e;
        a = mk(300, {1'b1, 29'($urandom)});
        b = mk(298, {1'b1, 29'($urandom)});
        e = ref_add(a, b);
        @(negedge clk);
        a_original = a; b_original = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_original = mk(511, '1); b_original = mk(511, '1);
            @(negedge clk);
            n_checks++;
            if ({kh, sum} !== e || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL hold[%0d]: got kh=%b sum=%h ov=%b, want kh=%b sum=%h ov=0",
                         i, kh, sum, out_valid, e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] a, b;
        logic [W:0]   e;
        @(negedge clk);
        a_original = mk(20, {1'b1, 29'd5}); b_original = mk(20, {1'b1, 29'd9}); in_valid = 1'b1;
        @(negedge clk);
        a_original = mk(30, {1'b1, 29'd1});
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (sum !== '0 || kh !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_immediate: got sum=%h kh=%b ov=%b, want 0 0 0", sum, kh, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (sum !== '0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_held: got sum=%h ov=%b, want 0 0", sum, out_valid);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            n_errors++;
            $display("FAIL rst_no_stale: got sum=%h ov=%b, want 0 0", sum, out_valid);
        end
        a = mk(12, {1'b1, 29'($urandom)});
        b = mk(10, {1'b1, 29'($urandom)});
        e = ref_add(a, b);
        a_original = a; b_original = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({kh, sum} !== e || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_first_out: got kh=%b sum=%h ov=%b, want kh=%b sum=%h ov=1",
                     kh, sum, out_valid, e[W], e[W-1:0]);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_ov_pulse: got ov=%b, want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back(400);
        test_commutative(20);
        test_hold();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
